// File: rtl/dbg_step_responder_if.sv
// dbg_step_responder_if: signal bundle between the debug link, the core, the
// register file and the step responder.
interface dbg_step_responder_if;
    logic        dbg_halt_req;
    logic        dbg_clock;
    logic [4:0]  dbg_reg_select;
    logic [31:0] cpu_pc;
    logic [31:0] cpu_instr;
    logic        cpu_ce;
    logic [4:0]  rf_dbg_addr;
    logic [31:0] rf_dbg_data;
    logic [31:0] dbg_pc;
    logic [10:0] dbg_instr;
    logic [31:0] dbg_code;
    logic [31:0] dbg_reg_bus;

    modport slave (
        input  dbg_halt_req, dbg_clock, dbg_reg_select, cpu_pc, cpu_instr, rf_dbg_data,
        output cpu_ce, rf_dbg_addr, dbg_pc, dbg_instr, dbg_code, dbg_reg_bus
    );

    modport master (
        output dbg_halt_req, dbg_clock, dbg_reg_select, cpu_pc, cpu_instr, rf_dbg_data,
        input  cpu_ce, rf_dbg_addr, dbg_pc, dbg_instr, dbg_code, dbg_reg_bus
    );
endinterface

// File: rtl/dbg_step_responder.sv
// dbg_step_responder: turns host halt/step requests into a core clock enable,
// snapshots PC/instruction/status and serves debug register-file reads.
module dbg_step_responder #(
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 2,
    parameter int STEP_CNT_W    = 16
) (
    input logic                 clk,
    input logic                 reset_n,
    dbg_step_responder_if.slave bus
);
    typedef enum logic [1:0] {RUN = 2'd0, HALTED = 2'd1, STEP = 2'd2, SETTLE = 2'd3} state_t;
    localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;

    state_t                          state, state_n;
    logic [SYNC_STAGES-1:0]          halt_sync, clk_sync;
    logic [SYNC_STAGES-1:0][4:0]     sel_sync;
    logic                            clk_prev, halt_s, step_edge, settle_last, busy;
    logic                            pending, pending_n, overrun;
    logic [4:0]                      sel_s, sel_prev;
    logic [CW-1:0]                   settle_cnt;
    logic [STEP_CNT_W-1:0]           step_count;

    assign halt_s      = halt_sync[SYNC_STAGES-1];
    assign sel_s       = sel_sync[SYNC_STAGES-1];
    assign step_edge   = clk_sync[SYNC_STAGES-1] & ~clk_prev;
    assign busy        = (state == STEP) || (state == SETTLE);
    assign settle_last = (state == SETTLE) && (settle_cnt == CW'(SETTLE_CYCLES - 1));
    assign bus.cpu_ce  = (state == RUN) || (state == STEP);

    // Halt synchronizer resets high so the core comes out of reset halted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            halt_sync <= '1;
            clk_sync  <= '0;
            sel_sync  <= '0;
            clk_prev  <= 1'b0;
            sel_prev  <= 5'd0;
        end else begin
            halt_sync <= {halt_sync[SYNC_STAGES-2:0], bus.dbg_halt_req};
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], bus.dbg_clock};
            sel_sync  <= {sel_sync[SYNC_STAGES-2:0], bus.dbg_reg_select};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
            sel_prev  <= sel_s;
        end
    end

    always_comb begin
        state_n   = state;
        pending_n = pending;
        case (state)
            HALTED:  state_n = !halt_s ? RUN : (step_edge || pending) ? STEP : HALTED;
            RUN:     state_n = halt_s ? HALTED : RUN;
            STEP:    state_n = SETTLE;
            default: state_n = settle_last ? (halt_s ? HALTED : RUN) : SETTLE;
        endcase
        if (busy && step_edge)
            pending_n = 1'b1;
        // Entering RUN discards a queued step, even one arriving this cycle
        if (state_n == STEP || (state_n == RUN && state != RUN))
            pending_n = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= HALTED;
            pending         <= 1'b0;
            overrun         <= 1'b0;
            step_count      <= '0;
            settle_cnt      <= '0;
            bus.dbg_pc      <= 32'd0;
            bus.dbg_instr   <= 11'd0;
            bus.dbg_code    <= 32'h0000_0001;
            bus.rf_dbg_addr <= 5'd0;
            bus.dbg_reg_bus <= 32'd0;
        end else begin
            state      <= state_n;
            pending    <= pending_n;
            settle_cnt <= (state == SETTLE) ? settle_cnt + 1'b1 : '0;
            if (busy && step_edge && pending)
                overrun <= 1'b1;
            if (state_n == STEP)
                step_count <= step_count + 1'b1;
            if (state == RUN || settle_last) begin
                bus.dbg_pc    <= bus.cpu_pc;
                bus.dbg_instr <= {bus.cpu_instr[30], bus.cpu_instr[14:12], bus.cpu_instr[6:0]};
            end
            bus.dbg_code <= {16'(step_count), 12'd0, overrun, pending, state};
            // Only a select value stable for two cycles is trusted
            if (sel_s == sel_prev)
                bus.rf_dbg_addr <= sel_s;
            bus.dbg_reg_bus <= (bus.rf_dbg_addr == 5'd0) ? 32'd0 : bus.rf_dbg_data;
        end
    end
endmodule

// File: tb/tb_dbg_step_responder.sv
// tb_dbg_step_responder: scenario tasks plus a cycle monitor comparing the
// responder against a step-window reference model.
module tb_dbg_step_responder;
    localparam int SYNC = 2;
    localparam int SETTLE = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [31:0] regs [32];
    int checks = 0;
    int errors = 0;

    dbg_step_responder_if bus();

    dbg_step_responder #(.SYNC_STAGES(SYNC), .SETTLE_CYCLES(SETTLE), .STEP_CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave)
    );

    always #5 clk = ~clk;
    assign bus.rf_dbg_data = regs[bus.rf_dbg_addr];

    // Model: m_busy counts down the cycles left in a step window (1 enable + SETTLE settle)
    bit          m_run, m_pend, m_ovr, m_clk_prev, m_h, m_e;
    int          m_busy;
    logic [15:0] m_cnt;
    logic [31:0] m_pc, m_code, m_bus;
    logic [10:0] m_instr;
    logic [4:0]  m_addr, m_sel_prev, m_s;
    bit          m_halt_q[$], m_clk_q[$];
    logic [4:0]  m_sel_q[$];

    function automatic int mstate();
        return m_run ? 0 : (m_busy == 0) ? 1 : (m_busy == SETTLE + 1) ? 2 : 3;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_halt_q.delete(); m_clk_q.delete(); m_sel_q.delete();
            for (int i = 0; i < SYNC; i++) begin
                m_halt_q.push_back(1'b1); m_clk_q.push_back(1'b0); m_sel_q.push_back(5'd0);
            end
            m_run = 0; m_busy = 0; m_pend = 0; m_ovr = 0; m_cnt = 0;
            m_pc = 0; m_instr = 0; m_code = 32'h1; m_bus = 0; m_addr = 0;
            m_sel_prev = 0; m_clk_prev = 0;
        end else begin
            m_h = m_halt_q[0];
            m_e = m_clk_q[0] && !m_clk_prev;
            m_s = m_sel_q[0];
            m_code = {m_cnt, 12'd0, m_ovr, m_pend, 2'(mstate())};
            m_bus = (m_addr == 0) ? 32'd0 : regs[m_addr];
            if (m_run || m_busy == 1) begin
                m_pc = bus.cpu_pc;
                m_instr = {bus.cpu_instr[30], bus.cpu_instr[14:12], bus.cpu_instr[6:0]};
            end
            if (m_s == m_sel_prev) m_addr = m_s;
            m_sel_prev = m_s;
            m_clk_prev = m_clk_q[0];
            if (m_busy > 0) begin
                if (m_e) begin
                    if (m_pend) m_ovr = 1; else m_pend = 1;
                end
                m_busy--;
                if (m_busy == 0) begin
                    m_run = !m_h;
                    if (!m_h) m_pend = 0;
                end
            end else if (m_run) begin
                m_run = !m_h;
            end else if (!m_h) begin
                m_run = 1; m_pend = 0;
            end else if (m_e || m_pend) begin
                m_busy = SETTLE + 1; m_pend = 0; m_cnt++;
            end
            void'(m_halt_q.pop_front()); m_halt_q.push_back(bus.dbg_halt_req);
            void'(m_clk_q.pop_front());  m_clk_q.push_back(bus.dbg_clock);
            void'(m_sel_q.pop_front());  m_sel_q.push_back(bus.dbg_reg_select);
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            checks += 6;
            if (bus.cpu_ce !== (m_run || m_busy == SETTLE + 1)) begin
                errors++; $display("FAIL mon_cpu_ce t=%0t got %b exp %b", $time, bus.cpu_ce, m_run || m_busy == SETTLE + 1);
            end
            if (bus.dbg_code !== m_code) begin
                errors++; $display("FAIL mon_dbg_code t=%0t got %h exp %h", $time, bus.dbg_code, m_code);
            end
            if (bus.dbg_pc !== m_pc) begin
                errors++; $display("FAIL mon_dbg_pc t=%0t got %h exp %h", $time, bus.dbg_pc, m_pc);
            end
            if (bus.dbg_instr !== m_instr) begin
                errors++; $display("FAIL mon_dbg_instr t=%0t got %h exp %h", $time, bus.dbg_instr, m_instr);
            end
            if (bus.rf_dbg_addr !== m_addr) begin
                errors++; $display("FAIL mon_rf_addr t=%0t got %0d exp %0d", $time, bus.rf_dbg_addr, m_addr);
            end
            if (bus.dbg_reg_bus !== m_bus) begin
                errors++; $display("FAIL mon_reg_bus t=%0t got %h exp %h", $time, bus.dbg_reg_bus, m_bus);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.dbg_halt_req = 1'b1; bus.dbg_clock = 1'b0; bus.dbg_reg_select = 5'd0;
        cyc(2);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        cyc(3);
        checks += 4;
        if (bus.cpu_ce !== 1'b0) begin errors++; $display("FAIL reset_ce got %b exp 0", bus.cpu_ce); end
        if (bus.dbg_code !== 32'h1) begin errors++; $display("FAIL reset_code got %h exp 00000001", bus.dbg_code); end
        if (bus.dbg_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", bus.dbg_pc); end
        if (bus.dbg_reg_bus !== 32'h0) begin errors++; $display("FAIL reset_reg_bus got %h exp 0", bus.dbg_reg_bus); end
    endtask

    task automatic test_single_step();
        int ce_cnt = 0;
        do_reset();
        bus.cpu_pc = 32'h0000_0104; bus.cpu_instr = 32'h40B5_0533;
        cyc(1);
        for (int i = 0; i < 14; i++) begin
            bus.dbg_clock = (i < 3);
            cyc(1);
            ce_cnt += int'(bus.cpu_ce);
        end
        checks += 4;
        if (ce_cnt != 1) begin errors++; $display("FAIL step_ce_cycles got %0d exp 1", ce_cnt); end
        if (bus.dbg_pc !== 32'h104) begin errors++; $display("FAIL step_pc got %h exp 00000104", bus.dbg_pc); end
        if (bus.dbg_instr !== 11'h433) begin errors++; $display("FAIL step_instr got %h exp 433", bus.dbg_instr); end
        if (bus.dbg_code !== 32'h0001_0001) begin errors++; $display("FAIL step_code got %h exp 00010001", bus.dbg_code); end
    endtask

    task automatic test_back_to_back();
        int ce_cnt = 0;
        do_reset();
        cyc(1);
        for (int i = 0; i < 30; i++) begin
            bus.dbg_clock = (i < 6) && (i % 2 == 0);
            cyc(1);
            ce_cnt += int'(bus.cpu_ce);
        end
        checks += 2;
        if (ce_cnt != 2) begin errors++; $display("FAIL b2b_ce_cycles got %0d exp 2", ce_cnt); end
        if (bus.dbg_code !== 32'h0002_0009) begin errors++; $display("FAIL b2b_code got %h exp 00020009", bus.dbg_code); end
    endtask

    task automatic test_run_halt();
        logic [31:0] pc, frozen;
        logic [31:0] ins;
        do_reset();
        cyc(1);
        bus.dbg_halt_req = 1'b0;
        cyc(SYNC);
        checks++;
        if (bus.cpu_ce !== 1'b0) begin errors++; $display("FAIL run_early_ce got %b exp 0", bus.cpu_ce); end
        cyc(1);
        checks++;
        if (bus.cpu_ce !== 1'b1) begin errors++; $display("FAIL run_ce got %b exp 1", bus.cpu_ce); end
        for (int i = 0; i < 8; i++) begin
            pc = $urandom; ins = $urandom;
            bus.cpu_pc = pc; bus.cpu_instr = ins;
            cyc(1);
            checks += 2;
            if (bus.dbg_pc !== pc) begin errors++; $display("FAIL run_track_pc got %h exp %h", bus.dbg_pc, pc); end
            if (bus.dbg_instr !== {ins[30], ins[14:12], ins[6:0]}) begin
                errors++; $display("FAIL run_track_instr got %h exp %h", bus.dbg_instr, {ins[30], ins[14:12], ins[6:0]});
            end
        end
        bus.dbg_halt_req = 1'b1;
        frozen = 32'd0;
        for (int i = 0; i < 10; i++) begin
            pc = $urandom;
            bus.cpu_pc = pc;
            cyc(1);
            if (i <= SYNC) frozen = pc;
            checks += 2;
            if (bus.dbg_pc !== frozen) begin errors++; $display("FAIL halt_pc i=%0d got %h exp %h", i, bus.dbg_pc, frozen); end
            if (bus.cpu_ce !== (i < SYNC)) begin errors++; $display("FAIL halt_ce i=%0d got %b exp %b", i, bus.cpu_ce, i < SYNC); end
        end
    endtask

    task automatic test_reg_select();
        do_reset();
        regs[5] = 32'hDEAD_BEEF;
        cyc(1);
        bus.dbg_reg_select = 5'd5;
        cyc(4);
        checks += 2;
        if (bus.rf_dbg_addr !== 5'd5) begin errors++; $display("FAIL sel_addr got %0d exp 5", bus.rf_dbg_addr); end
        if (bus.dbg_reg_bus !== 32'h0) begin errors++; $display("FAIL sel_bus_lag got %h exp 0", bus.dbg_reg_bus); end
        cyc(1);
        checks++;
        if (bus.dbg_reg_bus !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sel_bus got %h exp deadbeef", bus.dbg_reg_bus); end
        bus.dbg_reg_select = 5'd7;
        cyc(1);
        bus.dbg_reg_select = 5'd5;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            checks += 2;
            if (bus.rf_dbg_addr !== 5'd5) begin errors++; $display("FAIL glitch_addr got %0d exp 5", bus.rf_dbg_addr); end
            if (bus.dbg_reg_bus !== 32'hDEAD_BEEF) begin errors++; $display("FAIL glitch_bus got %h exp deadbeef", bus.dbg_reg_bus); end
        end
        bus.dbg_reg_select = 5'd0;
        cyc(6);
        checks += 2;
        if (bus.rf_dbg_addr !== 5'd0) begin errors++; $display("FAIL sel0_addr got %0d exp 0", bus.rf_dbg_addr); end
        if (bus.dbg_reg_bus !== 32'h0) begin errors++; $display("FAIL sel0_bus got %h exp 0 (rf data %h)", bus.dbg_reg_bus, regs[0]); end
    endtask

    task automatic test_reset_mid_step();
        bit found = 0;
        do_reset();
        cyc(1);
        for (int i = 0; i < 40 && !found; i++) begin
            bus.dbg_clock = (i < 6) && (i % 2 == 0);
            cyc(1);
            found = (m_busy == SETTLE + 1) && m_ovr;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL midreset_no_second_step got 0 exp 1");
        end else begin
            checks++;
            if (bus.cpu_ce !== 1'b1) begin errors++; $display("FAIL midreset_pre_ce got %b exp 1", bus.cpu_ce); end
            #2 reset_n = 1'b0;
            #1;
            checks += 2;
            if (bus.cpu_ce !== 1'b0) begin errors++; $display("FAIL midreset_ce got %b exp 0", bus.cpu_ce); end
            if (bus.dbg_code !== 32'h1) begin errors++; $display("FAIL midreset_code got %h exp 00000001", bus.dbg_code); end
            cyc(2);
            bus.dbg_clock = 1'b0;
            reset_n = 1'b1;
            cyc(3);
            checks += 2;
            if (bus.dbg_code !== 32'h1) begin errors++; $display("FAIL postreset_code got %h exp 00000001", bus.dbg_code); end
            if (bus.cpu_ce !== 1'b0) begin errors++; $display("FAIL postreset_ce got %b exp 0", bus.cpu_ce); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) bus.dbg_halt_req = ~bus.dbg_halt_req;
            if ($urandom_range(0, 2) == 0) bus.dbg_clock = ~bus.dbg_clock;
            if ($urandom_range(0, 3) == 0) bus.dbg_reg_select = 5'($urandom);
            bus.cpu_pc = $urandom; bus.cpu_instr = $urandom;
            cyc(1);
        end
        bus.dbg_halt_req = 1'b1; bus.dbg_clock = 1'b0;
        cyc(20);
        checks += 2;
        if (bus.cpu_ce !== 1'b0) begin errors++; $display("FAIL rand_end_ce got %b exp 0", bus.cpu_ce); end
        if (bus.dbg_code[1:0] !== 2'd1) begin errors++; $display("FAIL rand_end_state got %0d exp 1", bus.dbg_code[1:0]); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = regs[0] | 32'h1;
        bus.dbg_halt_req = 1'b1; bus.dbg_clock = 1'b0; bus.dbg_reg_select = 5'd0;
        bus.cpu_pc = 32'd0; bus.cpu_instr = 32'd0;
        test_reset();
        test_single_step();
        test_back_to_back();
        test_run_halt();
        test_reg_select();
        test_reset_mid_step();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
